// File: rtl/bitty_pkg.sv
// Shared types and default widths for the bitty program sequencer.
package bitty_pkg;

    localparam int unsigned BITTY_ADDR_W  = 8;
    localparam int unsigned BITTY_INSTR_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StExec,
        StHalted
    } seq_state_t;

    // Width needed to hold 0..max_val, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bitty_pc_unit.sv
// Program counter register with the branch/increment next-PC mux.
module bitty_pc_unit
    import bitty_pkg::*;
#(
    parameter int unsigned ADDR_W   = BITTY_ADDR_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] next_pc_o
);

    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_q;

    // Next PC is exposed combinationally so the breakpoint compare sees it before the load.
    always_comb begin
        next_pc_o = br_taken_i ? br_target_i : (pc_q + ADDR_W'(1));
    end

    // PC loads on instruction completion only.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= ResetPc;
        end else if (load_i) begin
            pc_q <= next_pc_o;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/bitty_seq.sv
// Fetch/issue/execute sequencer for the bitty core: owns the PC, drives instruction
// memory, and adds single-step, halt request, breakpoint and an execute watchdog.
module bitty_seq
    import bitty_pkg::*;
#(
    parameter int unsigned ADDR_W     = BITTY_ADDR_W,
    parameter int unsigned INSTR_W    = BITTY_INSTR_W,
    parameter int unsigned FETCH_WAIT = 1,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               resume,
    input  logic               halt_req,
    input  logic               bp_en,
    input  logic [ADDR_W-1:0]  bp_addr,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               core_run,
    output logic [INSTR_W-1:0] core_instr,
    input  logic               core_done,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               err_timeout,
    output logic [CNT_W-1:0]   retired
);

    localparam int unsigned FwW = cnt_width(FETCH_WAIT);
    localparam int unsigned ToW = cnt_width(TIMEOUT);
    localparam logic [FwW-1:0] FwLast = FwW'((FETCH_WAIT == 0) ? 0 : FETCH_WAIT - 1);
    localparam logic [ToW-1:0] ToLast = ToW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    seq_state_t         state_q;
    logic               core_run_q;
    logic [INSTR_W-1:0] core_instr_q;
    logic               halted_q;
    logic               err_q;
    logic [CNT_W-1:0]   retired_q;
    logic               halt_pend_q;
    logic               step_mode_q;
    logic [FwW-1:0]     fetch_cnt_q;
    logic [ToW-1:0]     wdog_q;

    logic               exec_done;
    logic [ADDR_W-1:0]  next_pc;
    logic               bp_hit;
    logic               wdog_expire;

    // Completion is only honoured in EXEC; stray core_done elsewhere has no effect.
    always_comb begin
        exec_done   = (state_q == StExec) && core_done;
        bp_hit      = bp_en && (next_pc == bp_addr);
        wdog_expire = (TIMEOUT != 0) && (wdog_q == ToLast);
    end

    bitty_pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (exec_done),
        .br_taken_i  (br_taken),
        .br_target_i (br_target),
        .pc_o        (pc),
        .next_pc_o   (next_pc)
    );

    // Sequencer FSM with registered outputs, fetch latency, watchdog and retire count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            core_run_q   <= 1'b0;
            core_instr_q <= '0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
            retired_q    <= '0;
            halt_pend_q  <= 1'b0;
            step_mode_q  <= 1'b0;
            fetch_cnt_q  <= '0;
            wdog_q       <= '0;
        end else begin
            core_run_q <= 1'b0;
            // Entering HALTED below clears this again, so a pending halt is consumed once.
            if (halt_req) begin
                halt_pend_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (halt_pend_q) begin
                        state_q     <= StHalted;
                        halted_q    <= 1'b1;
                        halt_pend_q <= 1'b0;
                    end else if (step) begin
                        state_q     <= StFetch;
                        step_mode_q <= 1'b1;
                        fetch_cnt_q <= '0;
                    end else if (run) begin
                        state_q     <= StFetch;
                        step_mode_q <= 1'b0;
                        fetch_cnt_q <= '0;
                    end
                end
                StFetch: begin
                    if (fetch_cnt_q == FwLast) begin
                        core_instr_q <= mem_rdata;
                        core_run_q   <= 1'b1;
                        state_q      <= StIssue;
                    end else begin
                        fetch_cnt_q <= fetch_cnt_q + FwW'(1);
                    end
                end
                StIssue: begin
                    state_q <= StExec;
                    wdog_q  <= '0;
                end
                StExec: begin
                    if (core_done) begin
                        retired_q <= retired_q + CNT_W'(1);
                        if (halt_pend_q || step_mode_q || bp_hit) begin
                            state_q     <= StHalted;
                            halted_q    <= 1'b1;
                            halt_pend_q <= 1'b0;
                        end else if (run) begin
                            state_q     <= StFetch;
                            fetch_cnt_q <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (wdog_expire) begin
                        err_q       <= 1'b1;
                        state_q     <= StHalted;
                        halted_q    <= 1'b1;
                        halt_pend_q <= 1'b0;
                    end else begin
                        wdog_q <= wdog_q + ToW'(1);
                    end
                end
                StHalted: begin
                    if (step) begin
                        state_q     <= StFetch;
                        step_mode_q <= 1'b1;
                        fetch_cnt_q <= '0;
                        halted_q    <= 1'b0;
                    end else if (resume) begin
                        halted_q    <= 1'b0;
                        step_mode_q <= 1'b0;
                        fetch_cnt_q <= '0;
                        state_q     <= run ? StFetch : StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_addr    = pc;
    assign core_run    = core_run_q;
    assign core_instr  = core_instr_q;
    assign halted      = halted_q;
    assign err_timeout = err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_bitty_seq.sv
// Directed, self-checking bench for bitty_seq: a per-cycle vector table for free-run and
// branching, plus hand sequences for step, breakpoint, watchdog, halt and reset corners.
module tb_bitty_seq;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic        resume;
    logic        halt_req;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        core_run;
    logic [15:0] core_instr;
    logic        core_done;
    logic        br_taken;
    logic [7:0]  br_target;
    logic [7:0]  pc;
    logic        halted;
    logic        err_timeout;
    logic [15:0] retired;

    int tests;
    int fails;
    int run_cnt;
    int cd;
    bit auto_en;

    bitty_seq #(
        .ADDR_W     (8),
        .INSTR_W    (16),
        .FETCH_WAIT (1),
        .TIMEOUT    (10),
        .CNT_W      (16),
        .RESET_PC   (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .resume      (resume),
        .halt_req    (halt_req),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .core_run    (core_run),
        .core_instr  (core_instr),
        .core_done   (core_done),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .pc          (pc),
        .halted      (halted),
        .err_timeout (err_timeout),
        .retired     (retired)
    );

    // Instruction memory: word at address a is {8'hA5, a}.
    assign mem_rdata = {8'hA5, mem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        done;
        logic        br;
        logic [7:0]  tgt;
        logic        exp_run;
        logic [7:0]  exp_pc;
        logic [15:0] exp_ret;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; outputs are then sampled 1 time unit after the edge. With auto_en the bench
    // plays the core, raising core_done in the third EXEC cycle after each core_run.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_en) begin
            core_done = 1'b0;
            if (cd != 0) begin
                cd--;
                if (cd == 0) core_done = 1'b1;
            end
        end
        if (core_run) begin
            run_cnt++;
            if (auto_en) cd = 3;
        end
        chk("run_while_halted", 32'(core_run & halted), 32'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        resume    = 1'b0;
        halt_req  = 1'b0;
        bp_en     = 1'b0;
        bp_addr   = 8'h00;
        core_done = 1'b0;
        br_taken  = 1'b0;
        br_target = 8'h00;
        auto_en   = 1'b0;
        cd        = 0;
        tick();
        tick();
        reset   = 1'b0;
        run_cnt = 0;
    endtask

    task automatic add(input logic r, input logic d, input logic b, input logic [7:0] t,
                       input logic er, input logic [7:0] ep, input logic [15:0] et,
                       input logic [15:0] ei);
        vec_t v;
        v.run = r; v.done = d; v.br = b; v.tgt = t;
        v.exp_run = er; v.exp_pc = ep; v.exp_ret = et; v.exp_instr = ei;
        vecs.push_back(v);
    endtask

    task automatic wait_halted(input int budget);
        for (int i = 0; i < budget && !halted; i++) tick();
    endtask

    task automatic wait_core_run(input int budget);
        for (int i = 0; i < budget && !core_run; i++) tick();
    endtask

    initial begin
        logic [7:0]  pc_m;
        logic [15:0] ret_m;
        logic [15:0] ins_m;
        logic        brs;
        logic [7:0]  tgt;

        tests = 0;
        fails = 0;

        // Free-run table: instruction k takes FETCH, ISSUE, EXEC x3 (done in the third).
        // k=5 (pc 5) branches to 8'h40, k=6 branches to 8'hFF, k=7 at 8'hFF wraps to 0.
        pc_m  = 8'h00;
        ret_m = 16'd0;
        ins_m = 16'h0000;
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, pc_m, ret_m, ins_m);
        for (int k = 0; k < 8; k++) begin
            brs   = (k == 5) || (k == 6);
            tgt   = (k == 5) ? 8'h40 : ((k == 6) ? 8'hFF : 8'h00);
            ins_m = {8'hA5, pc_m};
            add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, pc_m, ret_m, ins_m);
            for (int j = 0; j < 3; j++) add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, pc_m, ret_m, ins_m);
            pc_m  = brs ? tgt : pc_m + 8'd1;
            ret_m = ret_m + 16'd1;
            add((k != 7), 1'b1, brs, tgt, 1'b0, pc_m, ret_m, ins_m);
        end
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, pc_m, ret_m, ins_m);

        // Reset state.
        do_reset();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_core_run", 32'(core_run), 32'h0);
        chk("rst_core_instr", 32'(core_instr), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);

        foreach (vecs[i]) begin
            run       = vecs[i].run;
            core_done = vecs[i].done;
            br_taken  = vecs[i].br;
            br_target = vecs[i].tgt;
            tick();
            chk($sformatf("vec%0d_core_run", i), 32'(core_run), 32'(vecs[i].exp_run));
            chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_retired", i), 32'(retired), 32'(vecs[i].exp_ret));
            chk($sformatf("vec%0d_instr", i), 32'(core_instr), 32'(vecs[i].exp_instr));
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'h0);
        end
        core_done = 1'b0;
        br_taken  = 1'b0;
        chk("table_run_cnt", 32'(run_cnt), 32'd8);

        // Single-step from IDLE with run low, then a second step from HALTED.
        do_reset();
        auto_en = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_halted(30);
        chk("step1_halted", 32'(halted), 32'h1);
        chk("step1_pc", 32'(pc), 32'h1);
        chk("step1_runs", 32'(run_cnt), 32'd1);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step2_leaves_halt", 32'(halted), 32'h0);
        wait_halted(30);
        chk("step2_halted", 32'(halted), 32'h1);
        chk("step2_pc", 32'(pc), 32'h2);
        chk("step2_runs", 32'(run_cnt), 32'd2);
        chk("step2_retired", 32'(retired), 32'd2);

        // step and run together in IDLE: single-step wins.
        do_reset();
        auto_en = 1'b1;
        run  = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_halted(30);
        chk("steprun_halted", 32'(halted), 32'h1);
        chk("steprun_pc", 32'(pc), 32'h1);
        chk("steprun_runs", 32'(run_cnt), 32'd1);

        // Breakpoint on next_pc == 3, then resume executes instruction 3 without re-halting.
        do_reset();
        auto_en = 1'b1;
        bp_en   = 1'b1;
        bp_addr = 8'h03;
        run     = 1'b1;
        wait_halted(100);
        chk("bp_halted", 32'(halted), 32'h1);
        chk("bp_pc", 32'(pc), 32'h3);
        chk("bp_retired", 32'(retired), 32'd3);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("bp_resume_clears", 32'(halted), 32'h0);
        for (int i = 0; i < 60 && retired != 16'd5; i++) tick();
        chk("bp_cont_retired", 32'(retired), 32'd5);
        chk("bp_cont_pc", 32'(pc), 32'h5);
        chk("bp_cont_halted", 32'(halted), 32'h0);

        // Watchdog: core_done withheld for 10 EXEC cycles.
        do_reset();
        run = 1'b1;
        wait_core_run(20);
        chk("wd_issue", 32'(core_run), 32'h1);
        run = 1'b0;
        repeat (10) tick();
        chk("wd_not_yet", 32'(halted), 32'h0);
        chk("wd_no_err_yet", 32'(err_timeout), 32'h0);
        tick();
        chk("wd_halted", 32'(halted), 32'h1);
        chk("wd_err", 32'(err_timeout), 32'h1);
        chk("wd_pc", 32'(pc), 32'h0);
        chk("wd_retired", 32'(retired), 32'd0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        chk("wd_late_done_ret", 32'(retired), 32'd0);
        chk("wd_late_done_pc", 32'(pc), 32'h0);
        chk("wd_late_done_halt", 32'(halted), 32'h1);
        auto_en = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_halted(30);
        chk("wd_step_pc", 32'(pc), 32'h1);
        chk("wd_err_sticky", 32'(err_timeout), 32'h1);
        do_reset();
        chk("wd_err_reset", 32'(err_timeout), 32'h0);

        // halt_req during EXEC: the in-flight instruction still retires.
        do_reset();
        auto_en = 1'b1;
        run = 1'b1;
        wait_core_run(20);
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        wait_halted(30);
        chk("hr_halted", 32'(halted), 32'h1);
        chk("hr_retired", 32'(retired), 32'd1);
        chk("hr_pc", 32'(pc), 32'h1);
        chk("hr_runs", 32'(run_cnt), 32'd1);

        // Reset during EXEC, then a stale core_done after reset.
        do_reset();
        auto_en = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 30 && retired != 16'd1; i++) tick();
        chk("rx_first_retired", 32'(retired), 32'd1);
        wait_core_run(20);
        tick();
        tick();
        auto_en   = 1'b0;
        cd        = 0;
        core_done = 1'b0;
        reset     = 1'b1;
        run       = 1'b0;
        tick();
        reset = 1'b0;
        chk("rx_pc", 32'(pc), 32'h0);
        chk("rx_retired", 32'(retired), 32'd0);
        chk("rx_core_run", 32'(core_run), 32'h0);
        chk("rx_core_instr", 32'(core_instr), 32'h0);
        chk("rx_halted", 32'(halted), 32'h0);
        chk("rx_err", 32'(err_timeout), 32'h0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        chk("rx_stale_done_ret", 32'(retired), 32'd0);
        chk("rx_stale_done_pc", 32'(pc), 32'h0);
        chk("rx_stale_done_run", 32'(core_run), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
